// File: rtl/stream_demux.sv
// stream_demux: 1-to-4 stream demultiplexer with valid/ready handshakes.
//
// Each accepted input beat is steered by in_sel into a one-entry register
// for that channel. A beat addressed to a channel whose chan_en bit is low
// is consumed and counted in a saturating drop counter instead. All
// outputs are registered, so a pushed beat appears one cycle after accept.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Valid never waits for ready. While valid is high and ready is
// low, the sender holds its payload stable.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   producer handshake (in_ready is combinational)
//   in_sel, in_data     destination channel and payload of the input beat
//   chan_en[3:0]        per-channel enable; 0 drops beats to that channel
//   out_valid[3:0]      channel i register holds a beat
//   out_ready[3:0]      consumer i takes its beat this cycle
//   out_data0..3        channel payloads, retained after pop
//   drop_count          saturating count of dropped beats
module stream_demux #(
    parameter int WIDTH  = 8,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_sel,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [3:0]        chan_en,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [WIDTH-1:0]  out_data0,
    output logic [WIDTH-1:0]  out_data1,
    output logic [WIDTH-1:0]  out_data2,
    output logic [WIDTH-1:0]  out_data3,
    output logic [DROP_W-1:0] drop_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t       state_q [4];
    chan_state_t       state_d [4];
    logic [WIDTH-1:0]  data_q  [4];
    logic [DROP_W-1:0] drop_q;

    logic       accept;
    logic       drop;
    logic [3:0] push_vec;
    logic [3:0] pop_vec;

    // Channel state is visible directly as out_valid.
    always_comb begin
        out_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            out_valid[i] = (state_q[i] == FULL);
        end
    end

    // A channel can take a beat if it is disabled (drop), empty, or being
    // popped this cycle. Never looks at in_valid.
    assign in_ready = !chan_en[in_sel] || !out_valid[in_sel] || out_ready[in_sel];

    always_comb begin
        accept   = in_valid && in_ready;
        drop     = accept && !chan_en[in_sel];
        push_vec = 4'b0000;
        if (accept && chan_en[in_sel]) begin
            push_vec[in_sel] = 1'b1;
        end
        pop_vec = out_valid & out_ready;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                EMPTY:   if (push_vec[i]) state_d[i] = FULL;
                FULL:    if (pop_vec[i] && !push_vec[i]) state_d[i] = EMPTY;
                default: state_d[i] = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= EMPTY;
                data_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                // Data only moves on a push, so a held beat stays stable
                // and the last value is retained after pop.
                if (push_vec[i]) begin
                    data_q[i] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (drop && (drop_q != {DROP_W{1'b1}})) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign out_data0  = data_q[0];
    assign out_data1  = data_q[1];
    assign out_data2  = data_q[2];
    assign out_data3  = data_q[3];
    assign drop_count = drop_q;

endmodule

// File: tb/tb_stream_demux.sv
// Testbench for stream_demux: directed stimulus, per-channel expected
// queues filled by the driver on accept, drained by a monitor on pop.
module tb_stream_demux;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_sel;
    logic [7:0] in_data;
    logic [3:0] chan_en;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data0;
    logic [7:0] out_data1;
    logic [7:0] out_data2;
    logic [7:0] out_data3;
    logic [7:0] drop_count;

    int checks;
    int failures;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [7:0] exp_q2[$];
    logic [7:0] exp_q3[$];

    stream_demux #(.WIDTH(8), .DROP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .chan_en   (chan_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .drop_count(drop_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: act=%0h req=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] chan_data(input int i);
        case (i)
            0:       chan_data = out_data0;
            1:       chan_data = out_data1;
            2:       chan_data = out_data2;
            default: chan_data = out_data3;
        endcase
    endfunction

    task automatic push_exp(input logic [1:0] s, input logic [7:0] d);
        case (s)
            2'd0:    exp_q0.push_back(d);
            2'd1:    exp_q1.push_back(d);
            2'd2:    exp_q2.push_back(d);
            default: exp_q3.push_back(d);
        endcase
    endtask

    task automatic pop_check(input int i);
        logic [7:0] e;
        int sz;
        case (i)
            0:       sz = exp_q0.size();
            1:       sz = exp_q1.size();
            2:       sz = exp_q2.size();
            default: sz = exp_q3.size();
        endcase
        if (sz == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_unexpected ch%0d: act=%0h req=no_beat", i, chan_data(i));
        end else begin
            case (i)
                0:       e = exp_q0.pop_front();
                1:       e = exp_q1.pop_front();
                2:       e = exp_q2.pop_front();
                default: e = exp_q3.pop_front();
            endcase
            check($sformatf("pop_data_ch%0d", i), {24'h0, chan_data(i)}, {24'h0, e});
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && out_ready[i]) pop_check(i);
            end
        end
    end

    // driver: present a beat, wait (bounded) for in_ready, record on accept
    task automatic send(input logic [1:0] s, input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        if (chan_en[s]) push_exp(s, d);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 8'h00;
        chan_en   = 4'hF;
        out_ready = 4'h0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {28'h0, out_valid}, 32'h0);
        check("rst_drop_count", {24'h0, drop_count}, 32'h0);
        check("rst_out_data", {out_data0, out_data1, out_data2, out_data3}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // fill all four channels, 1-cycle latency each
        send(2'd0, 8'h11);
        check("lat_ch0", {31'h0, out_valid[0]}, 32'h1);
        send(2'd1, 8'h22);
        check("lat_ch1", {31'h0, out_valid[1]}, 32'h1);
        send(2'd2, 8'h33);
        check("lat_ch2", {31'h0, out_valid[2]}, 32'h1);
        send(2'd3, 8'h44);
        check("lat_ch3", {31'h0, out_valid[3]}, 32'h1);
        check("fill_valid", {28'h0, out_valid}, 32'hF);
        check("fill_data", {out_data0, out_data1, out_data2, out_data3}, 32'h11223344);

        // fifth beat to full channel 1 is blocked
        in_valid = 1'b1;
        in_sel   = 2'd1;
        in_data  = 8'h55;
        @(negedge clk);
        check("full_block_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk);
        #1 in_valid = 1'b0;

        // simultaneous pop and push on channel 1
        out_ready = 4'b0010;
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 8'hA5;
        @(negedge clk);
        check("poppush_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        push_exp(2'd1, 8'hA5);
        #1;
        out_ready = 4'b0000;
        in_valid  = 1'b0;
        check("poppush_valid", {31'h0, out_valid[1]}, 32'h1);
        check("poppush_data", {24'h0, out_data1}, 32'hA5);

        // channel 2 backpressure for 5 cycles; channel 0 drains meanwhile
        out_ready = 4'b0001;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        in_data   = 8'h66;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_ready", {31'h0, in_ready}, 32'h0);
            check("bp_stable", {24'h0, out_data2}, 32'h33);
            @(posedge clk);
            #1;
        end
        // producer switches to channel 0, accepted immediately
        in_sel  = 2'd0;
        in_data = 8'h77;
        @(negedge clk);
        check("switch_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        push_exp(2'd0, 8'h77);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 4'b0000;

        // drain everything
        out_ready = 4'hF;
        repeat (2) @(posedge clk);
        #1 out_ready = 4'h0;
        check("drained_valid", {28'h0, out_valid}, 32'h0);

        // drops to disabled channel 2
        chan_en = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            send(2'd2, 8'hD0 + k[7:0]);
            check("drop_no_valid", {31'h0, out_valid[2]}, 32'h0);
        end
        check("drop_count3", {24'h0, drop_count}, 32'h3);

        // 297 more drops: saturate at 255
        in_valid = 1'b1;
        in_sel   = 2'd2;
        in_data  = 8'hEE;
        repeat (297) @(posedge clk);
        #1 in_valid = 1'b0;
        check("drop_sat", {24'h0, drop_count}, 32'hFF);
        check("drop_sat_valid", {28'h0, out_valid}, 32'h0);

        // reset mid-operation
        chan_en = 4'hF;
        send(2'd0, 8'h81);
        send(2'd3, 8'h83);
        check("pre_rst_valid", {28'h0, out_valid}, 32'h9);
        rst = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
        exp_q3.delete();
        #1;
        check("rst_mid_valid", {28'h0, out_valid}, 32'h0);
        check("rst_mid_drop", {24'h0, drop_count}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        send(2'd3, 8'h99);
        check("post_rst_valid", {28'h0, out_valid}, 32'h8);
        check("post_rst_data", {24'h0, out_data3}, 32'h99);
        out_ready = 4'hF;
        repeat (2) @(posedge clk);
        #1 out_ready = 4'h0;
        check("final_queues_empty",
              exp_q0.size() + exp_q1.size() + exp_q2.size() + exp_q3.size(), 32'h0);
        check("final_valid", {28'h0, out_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
